// File: rtl/loop_sequencer_pkg.sv
// beat_pkg: shared recorder FSM state type, track indices and the silence note
// code used by the loop sequencer and its track players.
package beat_pkg;

    // Recorder FSM states
    typedef enum logic {
        IDLE = 1'b0,
        REC  = 1'b1
    } rec_state_t;

    // Track indices as carried on trk_sel / rec_trk
    localparam logic TRK_A = 1'b0;
    localparam logic TRK_B = 1'b1;

    // Note code meaning "no note"
    localparam int SILENCE = 0;

endpackage

// File: rtl/loop_sequencer_if.sv
// loop_sequencer_if: RAM-side bus of the loop sequencer (two single-port RAMs
// with independent addresses/write enables and one shared write-data bus).
interface loop_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int NOTE_W = 7
);
    logic [ADDR_W-1:0] ram_addr_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic              ram_wren_a;
    logic              ram_wren_b;
    logic [NOTE_W-1:0] ram_data;

    // Sequencer side drives the RAMs
    modport master (
        output ram_addr_a, ram_addr_b, ram_wren_a, ram_wren_b, ram_data
    );

    // RAM side consumes the bus
    modport slave (
        input ram_addr_a, ram_addr_b, ram_wren_a, ram_wren_b, ram_data
    );
endinterface

// File: rtl/loop_sequencer_track_player.sv
// track_player: loop read-address generator for one track. The address advances
// on each tick while the track plays, wraps at len-1, and returns to 0 whenever
// playback stops or a new recording of this track begins.
module track_player #(
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              tick,
    input  logic              play,
    input  logic              blocked,
    input  logic              restart,
    input  logic [ADDR_W:0]   len,
    output logic              playing,
    output logic [ADDR_W-1:0] rdAddr
);
    logic [ADDR_W-1:0] rdAddrReg;

    // A track plays only when requested, non-empty and not being recorded over
    always_comb begin
        playing = play && (len != '0) && !blocked && !reset;
    end

    // Loop address: hold 0 while stopped, step on tick, wrap at the last sample
    always_ff @(posedge CLOCK_50) begin
        if (reset || restart || !playing) begin
            rdAddrReg <= '0;
        end else if (tick) begin
            if (({1'b0, rdAddrReg} + (ADDR_W+1)'(1)) == len) begin
                rdAddrReg <= '0;
            end else begin
                rdAddrReg <= rdAddrReg + ADDR_W'(1);
            end
        end
    end

    assign rdAddr = rdAddrReg;

endmodule

// File: rtl/loop_sequencer.sv
// loop_sequencer: two-track note looper. Records live notes into RAM A or B on
// beat ticks and loops each recorded track independently.
// Optional macro LOOP_SEQ_AUTOSTOP_EN: a recording ends by itself once the
// track is full; without it a full track stays in REC until rec_btn.
module loop_sequencer #(
    parameter int ADDR_W = 8,
    parameter int NOTE_W = 7
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              tick,
    input  logic              rec_btn,
    input  logic              trk_sel,
    input  logic              play_a,
    input  logic              play_b,
    input  logic [NOTE_W-1:0] note_in,
    loop_sequencer_if.master  ram,
    output logic              playing_a,
    output logic              playing_b,
    output logic [ADDR_W:0]   len_a,
    output logic [ADDR_W:0]   len_b,
    output logic              recording,
    output logic              rec_trk,
    output logic              rec_done
);
    import beat_pkg::*;

    rec_state_t              stateReg;
    logic                    recTrkReg;
    logic                    recDoneReg;
    logic [1:0][ADDR_W:0]    lenReg;
    logic [ADDR_W:0]         recLen;
    logic                    recFull;
    logic                    recStart;
    logic                    wrEn;
    logic [1:0]              playReq;
    logic [1:0]              playingVec;
    logic [1:0]              wrenVec;
    logic [1:0][ADDR_W-1:0]  rdAddr;
    logic [1:0][ADDR_W-1:0]  ramAddr;

    // The write address is the length of the track being recorded
    always_comb begin
        recLen   = lenReg[recTrkReg];
        recFull  = recLen[ADDR_W];
        recStart = (stateReg == IDLE) && rec_btn;
        wrEn     = (stateReg == REC) && tick && !rec_btn && !recFull && !reset;
    end

    // Recorder FSM: start/stop on rec_btn, count written samples per track
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stateReg   <= IDLE;
            recTrkReg  <= TRK_A;
            recDoneReg <= 1'b0;
            lenReg     <= '0;
        end else begin
            recDoneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (rec_btn) begin
                        stateReg        <= REC;
                        recTrkReg       <= trk_sel;
                        lenReg[trk_sel] <= '0;
                    end
                end
                REC: begin
                    if (rec_btn) begin
                        stateReg   <= IDLE;
                        recDoneReg <= 1'b1;
                    end else if (wrEn) begin
                        lenReg[recTrkReg] <= recLen + (ADDR_W+1)'(1);
`ifdef LOOP_SEQ_AUTOSTOP_EN
                        // This write fills the last address: leave REC
                        if (&recLen[ADDR_W-1:0]) begin
                            stateReg   <= IDLE;
                            recDoneReg <= 1'b1;
                        end
`endif
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign playReq = {play_b, play_a};

    for (genvar gi = 0; gi < 2; gi++) begin : g_trk
        logic trkId;
        logic mine;
        assign trkId = (gi == 0) ? TRK_A : TRK_B;
        assign mine  = (stateReg == REC) && (recTrkReg == trkId);

        track_player #(.ADDR_W(ADDR_W)) u_player (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .tick     (tick),
            .play     (playReq[gi]),
            .blocked  (mine),
            .restart  (recStart && (trk_sel == trkId)),
            .len      (lenReg[gi]),
            .playing  (playingVec[gi]),
            .rdAddr   (rdAddr[gi])
        );

        assign ramAddr[gi] = mine ? recLen[ADDR_W-1:0] : rdAddr[gi];
        assign wrenVec[gi] = wrEn && mine;
    end

    assign ram.ram_addr_a = ramAddr[0];
    assign ram.ram_addr_b = ramAddr[1];
    assign ram.ram_wren_a = wrenVec[0];
    assign ram.ram_wren_b = wrenVec[1];
    assign ram.ram_data   = wrEn ? note_in : NOTE_W'(SILENCE);

    assign playing_a = playingVec[0];
    assign playing_b = playingVec[1];
    assign len_a     = lenReg[0];
    assign len_b     = lenReg[1];
    assign recording = (stateReg == REC);
    assign rec_trk   = recTrkReg;
    assign rec_done  = recDoneReg;

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: table vectors, directed corner sequences and random
// stimulus checked against a behavioural model of the looper.
module tb_loop_sequencer;
    localparam int AW    = 2;
    localparam int NW    = 7;
    localparam int DEPTH = 1 << AW;
    localparam int NV    = 20;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          tick = 1'b0;
    logic          btn  = 1'b0;
    logic          sel  = 1'b0;
    logic          pa   = 1'b0;
    logic          pb   = 1'b0;
    logic [NW-1:0] note = '0;
    logic          playing_a, playing_b, recording, rec_trk, rec_done;
    logic [AW:0]   len_a, len_b;

    int errors = 0;
    int checks = 0;
    bit modelOn = 1'b0;

    loop_sequencer_if #(.ADDR_W(AW), .NOTE_W(NW)) ramBus ();

    loop_sequencer #(.ADDR_W(AW), .NOTE_W(NW)) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .tick      (tick),
        .rec_btn   (btn),
        .trk_sel   (sel),
        .play_a    (pa),
        .play_b    (pb),
        .note_in   (note),
        .ram       (ramBus),
        .playing_a (playing_a),
        .playing_b (playing_b),
        .len_a     (len_a),
        .len_b     (len_b),
        .recording (recording),
        .rec_trk   (rec_trk),
        .rec_done  (rec_done)
    );

    always #5 clk = ~clk;

    // Track A RAM as seen by the sequencer
    logic [NW-1:0] memA [DEPTH];
    always @(posedge clk) begin
        if (ramBus.ram_wren_a) memA[ramBus.ram_addr_a] <= ramBus.ram_data;
    end

    // Behavioural model: recorder status, lengths, ticks since each loop began
    bit mRec, mTrk, mDone;
    int mLen [2];
    int mTicks [2];
    bit eWr;
    bit ePlay [2];
    int eAddr [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelEval();
        bit mine;
        bit pl;
        eWr = !rst && mRec && tick && !btn && (mLen[mTrk] < DEPTH);
        for (int x = 0; x < 2; x++) begin
            mine = mRec && (int'(mTrk) == x);
            pl = (x == 0) ? pa : pb;
            ePlay[x] = !rst && pl && (mLen[x] != 0) && !mine;
            if (mine) eAddr[x] = mLen[x] % DEPTH;
            else if (mLen[x] == 0) eAddr[x] = 0;
            else eAddr[x] = mTicks[x] % mLen[x];
        end
    endtask

    task automatic modelCheck();
        modelEval();
        chk("recording", int'(recording), int'(mRec));
        chk("rec_trk", int'(rec_trk), int'(mTrk));
        chk("rec_done", int'(rec_done), int'(mDone));
        chk("len_a", int'(len_a), mLen[0]);
        chk("len_b", int'(len_b), mLen[1]);
        chk("playing_a", int'(playing_a), int'(ePlay[0]));
        chk("playing_b", int'(playing_b), int'(ePlay[1]));
        chk("wren_a", int'(ramBus.ram_wren_a), int'(eWr && !mTrk));
        chk("wren_b", int'(ramBus.ram_wren_b), int'(eWr && mTrk));
        chk("addr_a", int'(ramBus.ram_addr_a), eAddr[0]);
        chk("addr_b", int'(ramBus.ram_addr_b), eAddr[1]);
        if (eWr) chk("ram_data", int'(ramBus.ram_data), int'(note));
    endtask

    task automatic modelUpdate();
        modelEval();
        if (rst) begin
            mRec = 0; mTrk = 0; mDone = 0;
            mLen = '{0, 0};
            mTicks = '{0, 0};
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (!ePlay[x]) mTicks[x] = 0;
                else if (tick) mTicks[x]++;
            end
            mDone = 0;
            if (!mRec) begin
                if (btn) begin
                    mTicks[sel] = 0;
                    mRec = 1; mTrk = sel; mLen[sel] = 0;
                end
            end else if (btn) begin
                mRec = 0; mDone = 1;
                $display("rec stop: trk=%0d len=%0d", mTrk, mLen[mTrk]);
            end else if (eWr) begin
                mLen[mTrk]++;
`ifdef LOOP_SEQ_AUTOSTOP_EN
                if (mLen[mTrk] == DEPTH) begin
                    mRec = 0; mDone = 1;
                    $display("rec autostop: trk=%0d len=%0d", mTrk, mLen[mTrk]);
                end
`endif
            end
        end
    endtask

    // Drive one cycle's inputs, then look at settled outputs on the falling edge
    task automatic setIn(input int r, input int t, input int b, input int s,
                         input int a, input int bb, input int n);
        rst = (r != 0); tick = (t != 0); btn = (b != 0); sel = (s != 0);
        pa = (a != 0); pb = (bb != 0); note = NW'(n);
        @(negedge clk);
        if (modelOn) modelCheck();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    typedef struct {
        int tk, bn, sl, pa, nt;
        int eWrA, eAddrA, eRec, eDone, eLenA, ePlayA, eData;
    } vec_t;
    vec_t tbl [NV];

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int aCnt;
        int wrCnt;
        bit rpa;
        bit rpb;
        //            tk bn sl pa  nt   wrA adA rec dn lenA plA data
        tbl[0]  = '{0, 0, 0, 0, 0,     0,  0,  0, 0, 0,  0, -1};
        tbl[1]  = '{0, 1, 0, 0, 0,     0,  0,  0, 0, 0,  0, -1};
        tbl[2]  = '{1, 0, 1, 0, 'h61,  1,  0,  1, 0, 0,  0, 'h61};
        tbl[3]  = '{0, 0, 1, 0, 0,     0,  1,  1, 0, 1,  0, -1};
        tbl[4]  = '{1, 0, 0, 0, 'h73,  1,  1,  1, 0, 1,  0, 'h73};
        tbl[5]  = '{1, 0, 0, 0, 'h64,  1,  2,  1, 0, 2,  0, 'h64};
        tbl[6]  = '{1, 1, 0, 0, 'h7a,  0,  3,  1, 0, 3,  0, -1};
        tbl[7]  = '{0, 0, 0, 0, 0,     0,  0,  0, 1, 3,  0, -1};
        tbl[8]  = '{0, 0, 0, 0, 0,     0,  0,  0, 0, 3,  0, -1};
        tbl[9]  = '{0, 0, 0, 1, 0,     0,  0,  0, 0, 3,  1, -1};
        tbl[10] = '{1, 0, 0, 1, 0,     0,  0,  0, 0, 3,  1, -1};
        tbl[11] = '{1, 0, 0, 1, 0,     0,  1,  0, 0, 3,  1, -1};
        tbl[12] = '{1, 0, 0, 1, 0,     0,  2,  0, 0, 3,  1, -1};
        tbl[13] = '{1, 0, 0, 1, 0,     0,  0,  0, 0, 3,  1, -1};
        tbl[14] = '{1, 0, 0, 1, 0,     0,  1,  0, 0, 3,  1, -1};
        tbl[15] = '{1, 0, 0, 1, 0,     0,  2,  0, 0, 3,  1, -1};
        tbl[16] = '{1, 0, 0, 1, 0,     0,  0,  0, 0, 3,  1, -1};
        tbl[17] = '{0, 0, 0, 1, 0,     0,  1,  0, 0, 3,  1, -1};
        tbl[18] = '{0, 0, 0, 0, 0,     0, -1,  0, 0, 3,  0, -1};
        tbl[19] = '{0, 0, 0, 0, 0,     0,  0,  0, 0, 3,  0, -1};

        // Reset state
        setIn(1, 0, 0, 0, 0, 0, 0); clockEdge();
        modelOn = 1'b1;
        setIn(1, 1, 1, 1, 1, 1, 5); clockEdge();
        setIn(0, 0, 0, 0, 0, 0, 0);
        chk("rst_recording", int'(recording), 0);
        chk("rst_len_a", int'(len_a), 0);
        chk("rst_len_b", int'(len_b), 0);
        chk("rst_rec_done", int'(rec_done), 0);
        chk("rst_playing_a", int'(playing_a), 0);
        chk("rst_addr_a", int'(ramBus.ram_addr_a), 0);
        $display("reset: recording=%0d len_a=%0d len_b=%0d", recording, len_a, len_b);
        clockEdge();

        // Record A then loop it
        for (int i = 0; i < NV; i++) begin
            setIn(0, tbl[i].tk, tbl[i].bn, tbl[i].sl, tbl[i].pa, 0, tbl[i].nt);
            chk($sformatf("tbl%0d_wren_a", i), int'(ramBus.ram_wren_a), tbl[i].eWrA);
            if (tbl[i].eAddrA >= 0)
                chk($sformatf("tbl%0d_addr_a", i), int'(ramBus.ram_addr_a), tbl[i].eAddrA);
            chk($sformatf("tbl%0d_recording", i), int'(recording), tbl[i].eRec);
            chk($sformatf("tbl%0d_rec_done", i), int'(rec_done), tbl[i].eDone);
            chk($sformatf("tbl%0d_len_a", i), int'(len_a), tbl[i].eLenA);
            chk($sformatf("tbl%0d_playing_a", i), int'(playing_a), tbl[i].ePlayA);
            if (tbl[i].eData >= 0)
                chk($sformatf("tbl%0d_ram_data", i), int'(ramBus.ram_data), tbl[i].eData);
            $display("vec %0d: wren_a=%0d addr_a=%0d rec=%0d done=%0d len_a=%0d play_a=%0d",
                     i, ramBus.ram_wren_a, ramBus.ram_addr_a, recording, rec_done, len_a, playing_a);
            clockEdge();
        end
        chk("memA0", int'(memA[0]), 'h61);
        chk("memA1", int'(memA[1]), 'h73);
        chk("memA2", int'(memA[2]), 'h64);

        // Record B while A loops; B must stay silent until its recording ends
        setIn(0, 0, 1, 1, 1, 1, 0); clockEdge();
        aCnt = 0;
        for (int i = 0; i < 6; i++) begin
            setIn(0, i % 2, 0, 0, 1, 1, 'h41 + i);
            chk("conc_wren_b", int'(ramBus.ram_wren_b), i % 2);
            chk("conc_playing_b", int'(playing_b), 0);
            chk("conc_addr_a", int'(ramBus.ram_addr_a), aCnt % 3);
            $display("conc %0d: wren_b=%0d addr_b=%0d addr_a=%0d",
                     i, ramBus.ram_wren_b, ramBus.ram_addr_b, ramBus.ram_addr_a);
            if (i % 2 == 1) aCnt++;
            clockEdge();
        end
        setIn(0, 0, 1, 0, 1, 1, 0); clockEdge();
        setIn(0, 0, 0, 0, 1, 1, 0);
        chk("conc_done", int'(rec_done), 1);
        chk("conc_playing_b_after", int'(playing_b), 1);
        chk("conc_len_b", int'(len_b), 3);
        clockEdge();

        // Play request on an empty track
        setIn(1, 0, 0, 0, 0, 0, 0); clockEdge();
        for (int i = 0; i < 3; i++) begin
            setIn(0, 1, 0, 0, 1, 0, 0);
            chk("empty_playing_a", int'(playing_a), 0);
            $display("empty %0d: playing_a=%0d", i, playing_a);
            clockEdge();
        end

        // Reset in the middle of a recording
        setIn(0, 0, 1, 0, 0, 0, 0); clockEdge();
        setIn(0, 1, 0, 0, 0, 0, 5); clockEdge();
        setIn(0, 1, 0, 0, 0, 0, 6); clockEdge();
        setIn(1, 1, 0, 0, 0, 0, 7); clockEdge();
        setIn(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_len_a", int'(len_a), 0);
        chk("midrst_recording", int'(recording), 0);
        chk("midrst_rec_done", int'(rec_done), 0);
        chk("midrst_wren_a", int'(ramBus.ram_wren_a), 0);
        chk("midrst_addr_a", int'(ramBus.ram_addr_a), 0);
        $display("midrst: len_a=%0d recording=%0d", len_a, recording);
        clockEdge();

        // Five ticks into a four-sample track
        setIn(0, 0, 1, 0, 0, 0, 0); clockEdge();
        wrCnt = 0;
        for (int i = 0; i < 5; i++) begin
            setIn(0, 1, 0, 0, 0, 0, i + 1);
            wrCnt += int'(ramBus.ram_wren_a);
            clockEdge();
        end
        setIn(0, 0, 0, 0, 0, 0, 0);
        chk("full_writes", wrCnt, 4);
        chk("full_len_a", int'(len_a), 4);
`ifdef LOOP_SEQ_AUTOSTOP_EN
        chk("full_recording", int'(recording), 0);
        clockEdge();
`else
        chk("full_recording", int'(recording), 1);
        clockEdge();
        setIn(0, 0, 1, 0, 0, 0, 0); clockEdge();
        setIn(0, 0, 0, 0, 0, 0, 0);
        chk("full_done", int'(rec_done), 1);
        chk("full_len_a_kept", int'(len_a), 4);
        clockEdge();
`endif
        $display("full: writes=%0d len_a=%0d", wrCnt, len_a);

        // Random traffic against the model
        rpa = 0; rpb = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rpa = !rpa;
            if ($urandom_range(0, 9) == 0) rpb = !rpb;
            setIn(int'($urandom_range(0, 199) == 0), int'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 11) == 0), int'($urandom_range(0, 1)),
                  int'(rpa), int'(rpb), int'($urandom_range(0, 127)));
            clockEdge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
